// File: rtl/mul_div_seq_pkg.sv
// Shared word length, op codes and sequencer state encodings for mul_div_seq.
package mul_div_seq_pkg;

    localparam int unsigned WORD_LENGTH = 32;

    typedef enum logic [1:0] {
        MDOP_MUL  = 2'b00,
        MDOP_MULH = 2'b01,
        MDOP_DIVU = 2'b10,
        MDOP_REMU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'b00,
        MDS_RUN  = 2'b01,
        MDS_DONE = 2'b10
    } mds_state_e;

    function automatic logic op_is_div(input md_op_e o);
        return (o == MDOP_DIVU) || (o == MDOP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_seq_adder.sv
// WIDTH-bit adder with carry-in and carry-out, shared by every multiply/divide step.
module AdderUnit
    import mul_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_LENGTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inC,
    output logic [WIDTH-1:0] sum,
    output logic             outC
);

    // Plain ripple add; the carry-out doubles as the divide step's "no borrow" flag.
    always_comb begin
        {outC, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, inC};
    end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply / divide sequencer: one adder step per cycle,
// start/done handshake, abort for pipeline flush.
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Vectors are numbered [WIDTH-1:0] here, so the MSB-first "bit 0" of the
    // original datapath is bit WIDTH-1 below and the LSB is bit 0.
    mds_state_e       state;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] breg;

    logic             is_div;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] res;

    AdderUnit #(.WIDTH(WIDTH)) u_add (
        .a   (add_a),
        .b   (add_b),
        .inC (add_ci),
        .sum (add_s),
        .outC(add_c)
    );

    // One shift-add (multiply) or restoring-subtract (divide) step on hi/lo.
    always_comb begin
        is_div = op_is_div(op_q);
        t      = {hi[WIDTH-2:0], lo[WIDTH-1]};
        add_a  = is_div ? t : hi;
        add_b  = is_div ? ~breg : (lo[0] ? breg : '0);
        add_ci = is_div;
        if (is_div) begin
            hi_nxt = add_c ? add_s : t;
            lo_nxt = {lo[WIDTH-2:0], add_c};
        end else begin
            hi_nxt = {add_c, add_s[WIDTH-1:1]};
            lo_nxt = {add_s[0], lo[WIDTH-1:1]};
        end
        res = ((op_q == MDOP_MUL) || (op_q == MDOP_DIVU)) ? lo_nxt : hi_nxt;
    end

    // Sequencer FSM with registered busy/done/r/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDS_IDLE;
            op_q  <= MDOP_MUL;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            breg  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                MDS_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q <= md_op_e'(op);
                        hi   <= '0;
                        lo   <= a;
                        breg <= b;
                        cnt  <= CNT_W'(WIDTH);
                        busy <= 1'b1;
                        if (op_is_div(md_op_e'(op)) && (b == '0)) begin
                            state <= MDS_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            r     <= (md_op_e'(op) == MDOP_DIVU) ? '1 : a;
                        end else begin
                            state <= MDS_RUN;
                        end
                    end
                end
                MDS_RUN: begin
                    if (abort) begin
                        state <= MDS_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= MDS_DONE;
                            done  <= 1'b1;
                            r     <= res;
                            err   <= 1'b0;
                        end
                    end
                end
                MDS_DONE: begin
                    state <= MDS_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= MDS_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed, table-driven bench for mul_div_seq plus hand-written protocol sequences.
module tb_mul_div_seq;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] r;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    mul_div_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .abort(abort),
        .busy (busy),
        .done (done),
        .r    (r),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Issues one operation; returns after the cycle following done (an IDLE cycle).
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rr, output logic e, output int lat,
                         output int busyc, output logic busy_after, output logic done_after);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        busyc = 0;
        rr    = '0;
        e     = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (busy) busyc++;
            if (done) begin
                lat = i;
                rr  = r;
                e   = err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        busy_after = busy;
        done_after = done;
    endtask

    initial begin
        logic [31:0] rr;
        logic        e;
        logic        ba;
        logic        da;
        int          lat;
        int          busyc;
        int          ndone;
        logic [31:0] r_prior;
        logic        err_prior;

        vecs[0]  = '{OP_MUL,  32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 33};
        vecs[1]  = '{OP_MULH, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 1'b0, 33};
        vecs[2]  = '{OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
        vecs[3]  = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[4]  = '{OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 33};
        vecs[5]  = '{OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 33};
        vecs[6]  = '{OP_DIVU, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 33};
        vecs[7]  = '{OP_REMU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33};
        vecs[8]  = '{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 33};
        vecs[9]  = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[10] = '{OP_REMU, 32'd5,         32'd0,         32'd5,         1'b1, 1};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err",  {31'b0, err},  32'd0);
        check("reset_r",    r,             32'd0);
        rst = 1'b0;

        // Table: each op starts in the cycle after the previous done.
        for (int v = 0; v < 11; v++) begin
            do_op(vecs[v].op, vecs[v].a, vecs[v].b, rr, e, lat, busyc, ba, da);
            check($sformatf("vec%0d_r", v),       rr,              vecs[v].r);
            check($sformatf("vec%0d_err", v),     {31'b0, e},      {31'b0, vecs[v].err});
            check($sformatf("vec%0d_latency", v), 32'(lat),        32'(vecs[v].lat));
            check($sformatf("vec%0d_busycyc", v), 32'(busyc),      32'(vecs[v].lat));
            check($sformatf("vec%0d_busy_end", v), {31'b0, ba},    32'd0);
            check($sformatf("vec%0d_done_1cyc", v), {31'b0, da},   32'd0);
            check($sformatf("vec%0d_r_hold", v),  r,               vecs[v].r);
        end

        // Abort at RUN cycle 10: outputs from the REMU-by-zero above must hold.
        r_prior   = 32'd5;
        err_prior = 1'b1;
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_r",    r,             r_prior);
        check("abort_err",  {31'b0, err},  {31'b0, err_prior});
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op(OP_MUL, 32'd3, 32'd4, rr, e, lat, busyc, ba, da);
        check("after_abort_r",   rr,          32'd12);
        check("after_abort_lat", 32'(lat),    32'd33);
        check("after_abort_err", {31'b0, e},  32'd0);

        // Start pulses while busy (RUN cycles 5 and 20, and the DONE cycle) are ignored.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        rr    = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (done) begin
                ndone++;
                rr = r;
            end
            if (cyc == 5 || cyc == 20 || cyc == 33) begin
                start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_r",     rr,         32'd42);
        check("busy_start_idle",  {31'b0, busy}, 32'd0);

        // Synchronous reset mid-RUN clears everything, no done afterwards.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_err",  {31'b0, err},  32'd0);
        check("rst_mid_r",    r,             32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);

        // Abort and start together in IDLE: start wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = OP_REMU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", {31'b0, busy}, 32'd1);
        ndone = 0;
        rr    = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                rr = r;
            end
            @(posedge clk);
            #1;
        end
        check("start_abort_idle_ndone", 32'(ndone), 32'd1);
        check("start_abort_idle_r",     rr,         32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
